// File: rtl/csr_trap_ctrl_if.sv
// Bundle between the pipeline/csr_file and the trap/mret CSR sequencer.
// The slave modport is the controller's view; the master modport is the environment's view.
interface csr_trap_ctrl_if;
    logic        wb_csr_wen;
    logic [11:0] wb_csr_waddr;
    logic [31:0] wb_csr_wdata;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_req;
    logic [31:0] mstatus_in;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        trap_ack;
    logic        mret_ack;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        wb_ovf;

    modport slave (
        input  wb_csr_wen, wb_csr_waddr, wb_csr_wdata,
        input  trap_req, trap_cause, trap_pc, trap_tval, mret_req,
        input  mstatus_in, mtvec_in, mepc_in,
        output csr_wen, csr_waddr, csr_wdata,
        output trap_ack, mret_ack, busy, redirect_valid, redirect_pc, wb_ovf
    );

    modport master (
        output wb_csr_wen, wb_csr_waddr, wb_csr_wdata,
        output trap_req, trap_cause, trap_pc, trap_tval, mret_req,
        output mstatus_in, mtvec_in, mepc_in,
        input  csr_wen, csr_waddr, csr_wdata,
        input  trap_ack, mret_ack, busy, redirect_valid, redirect_pc, wb_ovf
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Trap entry / mret CSR sequencer: arbitrates the csr_file write port between WB writes
// and a fixed mepc/mcause/mtval/mstatus write sequence, then issues a one-cycle fetch redirect.
//
// state   | meaning
// IDLE    | WB writes pass through, trap/mret requests accepted
// T_EPC   | write mepc (trap)
// T_CAUSE | write mcause (trap)
// T_TVAL  | write mtval (trap)
// T_STAT  | write mstatus trap-entry form (trap)
// M_STAT  | write mstatus mret form (mret)
// REDIR   | one-cycle redirect, then IDLE
module csr_trap_ctrl #(
    parameter int VEC_EN = 1
) (
    input logic            clk,
    input logic            rst,
    csr_trap_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] T_EPC   = 3'd1;
    localparam logic [2:0] T_CAUSE = 3'd2;
    localparam logic [2:0] T_TVAL  = 3'd3;
    localparam logic [2:0] T_STAT  = 3'd4;
    localparam logic [2:0] M_STAT  = 3'd5;
    localparam logic [2:0] REDIR   = 3'd6;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    logic [2:0]  state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:2] pc_q, pc_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        pend_v_q, pend_v_d;
    logic [11:0] pend_addr_q, pend_addr_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic        ovf_q, ovf_d;

    logic        wen_c;
    logic [11:0] waddr_c;
    logic [31:0] wdata_c;
    logic        trap_ack_c;
    logic        mret_ack_c;
    logic        redir_c;
    logic [31:0] mstat_trap;
    logic [31:0] mstat_mret;
    logic [31:0] trap_target;

    logic unused_bits;
    assign unused_bits = ^{bus.mepc_in[1:0], bus.trap_pc[1:0]};

    always_comb begin
        mstat_trap        = bus.mstatus_in;
        mstat_trap[7]     = bus.mstatus_in[3];
        mstat_trap[3]     = 1'b0;
        mstat_trap[12:11] = 2'b11;

        mstat_mret        = bus.mstatus_in;
        mstat_mret[3]     = bus.mstatus_in[7];
        mstat_mret[7]     = 1'b1;
        mstat_mret[12:11] = 2'b11;

        // Vectored mode only applies to interrupts; exceptions always go to the base.
        trap_target = {mtvec_q[31:2], 2'b00};
        if ((VEC_EN != 0) && (mtvec_q[1:0] == 2'b01) && cause_q[31])
            trap_target = {mtvec_q[31:2], 2'b00} + {cause_q[29:0], 2'b00};
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        pc_d        = pc_q;
        tval_d      = tval_q;
        mtvec_d     = mtvec_q;
        redir_pc_d  = redir_pc_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        ovf_d       = ovf_q;
        wen_c       = 1'b0;
        waddr_c     = 12'h000;
        wdata_c     = 32'h0;
        trap_ack_c  = 1'b0;
        mret_ack_c  = 1'b0;
        redir_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_v_q) begin
                    wen_c       = 1'b1;
                    waddr_c     = pend_addr_q;
                    wdata_c     = pend_data_q;
                    pend_v_d    = bus.wb_csr_wen;
                    pend_addr_d = bus.wb_csr_waddr;
                    pend_data_d = bus.wb_csr_wdata;
                end else if (bus.wb_csr_wen) begin
                    wen_c   = 1'b1;
                    waddr_c = bus.wb_csr_waddr;
                    wdata_c = bus.wb_csr_wdata;
                end
                if (bus.trap_req) begin
                    trap_ack_c = 1'b1;
                    cause_d    = bus.trap_cause;
                    pc_d       = bus.trap_pc[31:2];
                    tval_d     = bus.trap_tval;
                    mtvec_d    = bus.mtvec_in;
                    state_d    = T_EPC;
                end else if (bus.mret_req) begin
                    mret_ack_c = 1'b1;
                    state_d    = M_STAT;
                end
            end
            T_EPC: begin
                wen_c   = 1'b1;
                waddr_c = A_MEPC;
                wdata_c = {pc_q, 2'b00};
                state_d = T_CAUSE;
            end
            T_CAUSE: begin
                wen_c   = 1'b1;
                waddr_c = A_MCAUSE;
                wdata_c = cause_q;
                state_d = T_TVAL;
            end
            T_TVAL: begin
                wen_c   = 1'b1;
                waddr_c = A_MTVAL;
                wdata_c = tval_q;
                state_d = T_STAT;
            end
            T_STAT: begin
                wen_c      = 1'b1;
                waddr_c    = A_MSTATUS;
                wdata_c    = mstat_trap;
                redir_pc_d = trap_target;
                state_d    = REDIR;
            end
            M_STAT: begin
                wen_c      = 1'b1;
                waddr_c    = A_MSTATUS;
                wdata_c    = mstat_mret;
                redir_pc_d = {bus.mepc_in[31:2], 2'b00};
                state_d    = REDIR;
            end
            REDIR: begin
                redir_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // WB writes that arrive while the sequencer owns the port are buffered or lost.
        if ((state_q != IDLE) && bus.wb_csr_wen) begin
            if (pend_v_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_v_d    = 1'b1;
                pend_addr_d = bus.wb_csr_waddr;
                pend_data_d = bus.wb_csr_wdata;
            end
        end

        if (rst) begin
            wen_c      = 1'b0;
            waddr_c    = 12'h000;
            wdata_c    = 32'h0;
            trap_ack_c = 1'b0;
            mret_ack_c = 1'b0;
            redir_c    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cause_q     <= 32'h0;
            pc_q        <= 30'h0;
            tval_q      <= 32'h0;
            mtvec_q     <= 32'h0;
            redir_pc_q  <= 32'h0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= 12'h000;
            pend_data_q <= 32'h0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            pc_q        <= pc_d;
            tval_q      <= tval_d;
            mtvec_q     <= mtvec_d;
            redir_pc_q  <= redir_pc_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.csr_wen        = wen_c;
    assign bus.csr_waddr      = waddr_c;
    assign bus.csr_wdata      = wdata_c;
    assign bus.trap_ack       = trap_ack_c;
    assign bus.mret_ack       = mret_ack_c;
    assign bus.busy           = (state_q != IDLE);
    assign bus.redirect_valid = redir_c;
    assign bus.redirect_pc    = redir_c ? redir_pc_q : 32'h0;
    assign bus.wb_ovf         = ovf_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: trap/mret sequences, arbitration, WB buffering, reset abort.
module tb_csr_trap_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    csr_trap_ctrl_if bus ();

    csr_trap_ctrl #(.VEC_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.wb_csr_wen   = 1'b0;
        bus.wb_csr_waddr = 12'h0;
        bus.wb_csr_wdata = 32'h0;
        bus.trap_req     = 1'b0;
        bus.trap_cause   = 32'h0;
        bus.trap_pc      = 32'h0;
        bus.trap_tval    = 32'h0;
        bus.mret_req     = 1'b0;
        bus.mstatus_in   = 32'h0;
        bus.mtvec_in     = 32'h0;
        bus.mepc_in      = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.trap_req = 1'b1;
        bus.mret_req = 1'b1;
        bus.wb_csr_wen = 1'b1;
        bus.wb_csr_waddr = 12'h305;
        bus.wb_csr_wdata = 32'h1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if ({bus.busy, bus.trap_ack, bus.mret_ack, bus.redirect_valid, bus.wb_ovf} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {bus.busy, bus.trap_ack, bus.mret_ack, bus.redirect_valid, bus.wb_ovf}); end
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== 45'h0) begin failures++; $display("FAIL rst_port got=%h exp=0", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}); end
        checks++; if (bus.redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_redirect_pc got=%h exp=0", bus.redirect_pc); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_release_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_sync_trap();
        @(negedge clk);
        bus.mtvec_in = 32'h8000_0100; bus.trap_cause = 32'd2; bus.trap_pc = 32'h1004;
        bus.trap_tval = 32'hDEAD; bus.mstatus_in = 32'h8; bus.trap_req = 1'b1;
        #1;
        checks++; if ({bus.trap_ack, bus.mret_ack, bus.busy} !== 3'b100) begin failures++; $display("FAIL sync_accept got=%b exp=100", {bus.trap_ack, bus.mret_ack, bus.busy}); end
        checks++; if (bus.csr_wen !== 1'b0) begin failures++; $display("FAIL sync_accept_wen got=%b exp=0", bus.csr_wen); end
        @(negedge clk); bus.trap_req = 1'b0; bus.mtvec_in = 32'h0; #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h341, 32'h1004}) begin failures++; $display("FAIL sync_mepc got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h341, 32'h1004}); end
        checks++; if ({bus.busy, bus.trap_ack} !== 2'b10) begin failures++; $display("FAIL sync_busy got=%b exp=10", {bus.busy, bus.trap_ack}); end
        @(negedge clk); #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h342, 32'd2}) begin failures++; $display("FAIL sync_mcause got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h342, 32'd2}); end
        @(negedge clk); #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h343, 32'hDEAD}) begin failures++; $display("FAIL sync_mtval got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h343, 32'hDEAD}); end
        @(negedge clk); #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h300, 32'h1880}) begin failures++; $display("FAIL sync_mstatus got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h300, 32'h1880}); end
        @(negedge clk); #1;
        checks++; if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h8000_0100}) begin failures++; $display("FAIL sync_redirect got=%h exp=%h", {bus.redirect_valid, bus.redirect_pc}, {1'b1, 32'h8000_0100}); end
        checks++; if (bus.csr_wen !== 1'b0) begin failures++; $display("FAIL sync_redir_wen got=%b exp=0", bus.csr_wen); end
        @(negedge clk); #1;
        checks++; if ({bus.busy, bus.redirect_valid} !== 2'b00) begin failures++; $display("FAIL sync_done got=%b exp=00", {bus.busy, bus.redirect_valid}); end
    endtask

    task automatic test_vectored();
        @(negedge clk);
        idle_inputs();
        bus.mtvec_in = 32'h8000_0101; bus.trap_cause = 32'h8000_0007; bus.trap_pc = 32'h2003;
        bus.trap_req = 1'b1;
        #1;
        checks++; if (bus.trap_ack !== 1'b1) begin failures++; $display("FAIL vec_accept got=%b exp=1", bus.trap_ack); end
        @(negedge clk); bus.trap_req = 1'b0; #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h341, 32'h2000}) begin failures++; $display("FAIL vec_mepc_align got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h341, 32'h2000}); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); bus.mstatus_in = 32'hFFFF_FFFF; #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h300, 32'hFFFF_FFF7}) begin failures++; $display("FAIL vec_mstatus got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h300, 32'hFFFF_FFF7}); end
        @(negedge clk); bus.trap_req = 1'b1; bus.mret_req = 1'b1; #1;
        checks++; if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h8000_011C}) begin failures++; $display("FAIL vec_redirect got=%h exp=%h", {bus.redirect_valid, bus.redirect_pc}, {1'b1, 32'h8000_011C}); end
        checks++; if ({bus.trap_ack, bus.mret_ack} !== 2'b00) begin failures++; $display("FAIL vec_redir_ignore got=%b exp=00", {bus.trap_ack, bus.mret_ack}); end
        @(negedge clk); idle_inputs(); #1;
        checks++; if ({bus.busy, bus.redirect_valid} !== 2'b00) begin failures++; $display("FAIL vec_done got=%b exp=00", {bus.busy, bus.redirect_valid}); end
    endtask

    task automatic test_mret();
        @(negedge clk);
        idle_inputs();
        bus.mstatus_in = 32'h80; bus.mepc_in = 32'h9999; bus.mret_req = 1'b1;
        #1;
        checks++; if ({bus.mret_ack, bus.trap_ack, bus.busy} !== 3'b100) begin failures++; $display("FAIL mret_accept got=%b exp=100", {bus.mret_ack, bus.trap_ack, bus.busy}); end
        @(negedge clk); bus.mret_req = 1'b0; bus.mepc_in = 32'h2002; #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h300, 32'h1888}) begin failures++; $display("FAIL mret_mstatus got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h300, 32'h1888}); end
        checks++; if ({bus.busy, bus.mret_ack} !== 2'b10) begin failures++; $display("FAIL mret_busy got=%b exp=10", {bus.busy, bus.mret_ack}); end
        @(negedge clk); bus.mepc_in = 32'h5555; #1;
        checks++; if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h2000}) begin failures++; $display("FAIL mret_redirect got=%h exp=%h", {bus.redirect_valid, bus.redirect_pc}, {1'b1, 32'h2000}); end
        checks++; if (bus.csr_wen !== 1'b0) begin failures++; $display("FAIL mret_redir_wen got=%b exp=0", bus.csr_wen); end
        @(negedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mret_done got=%b exp=0", bus.busy); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        idle_inputs();
        bus.mtvec_in = 32'h200; bus.trap_cause = 32'hB; bus.trap_pc = 32'h10;
        bus.trap_req = 1'b1; bus.mret_req = 1'b1;
        bus.wb_csr_wen = 1'b1; bus.wb_csr_waddr = 12'h305; bus.wb_csr_wdata = 32'h40;
        #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h305, 32'h40}) begin failures++; $display("FAIL prio_wb_pass got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h305, 32'h40}); end
        checks++; if ({bus.trap_ack, bus.mret_ack} !== 2'b10) begin failures++; $display("FAIL prio_acks got=%b exp=10", {bus.trap_ack, bus.mret_ack}); end
        @(negedge clk); idle_inputs(); #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h341, 32'h10}) begin failures++; $display("FAIL prio_mepc got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h341, 32'h10}); end
        @(negedge clk); bus.wb_csr_wen = 1'b1; bus.wb_csr_waddr = 12'h343; bus.wb_csr_wdata = 32'h55; #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h342, 32'hB}) begin failures++; $display("FAIL prio_busy_port got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h342, 32'hB}); end
        @(negedge clk); bus.wb_csr_wen = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h200}) begin failures++; $display("FAIL prio_redirect got=%h exp=%h", {bus.redirect_valid, bus.redirect_pc}, {1'b1, 32'h200}); end
        @(negedge clk); bus.wb_csr_wen = 1'b1; bus.wb_csr_waddr = 12'h342; bus.wb_csr_wdata = 32'h66; #1;
        checks++; if ({bus.busy, bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b0, 1'b1, 12'h343, 32'h55}) begin failures++; $display("FAIL prio_pending_out got=%h exp=%h", {bus.busy, bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b0, 1'b1, 12'h343, 32'h55}); end
        @(negedge clk); bus.wb_csr_wen = 1'b0; #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h342, 32'h66}) begin failures++; $display("FAIL prio_replaced got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h342, 32'h66}); end
        @(negedge clk); #1;
        checks++; if ({bus.csr_wen, bus.wb_ovf} !== 2'b00) begin failures++; $display("FAIL prio_drained got=%b exp=00", {bus.csr_wen, bus.wb_ovf}); end
    endtask

    task automatic test_wb_overflow();
        @(negedge clk);
        idle_inputs();
        bus.mtvec_in = 32'h300; bus.trap_cause = 32'd1; bus.trap_pc = 32'h40; bus.trap_req = 1'b1;
        @(negedge clk); bus.trap_req = 1'b0;
        bus.wb_csr_wen = 1'b1; bus.wb_csr_waddr = 12'h305; bus.wb_csr_wdata = 32'h111; #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h341, 32'h40}) begin failures++; $display("FAIL ovf_seq_port got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h341, 32'h40}); end
        @(negedge clk); bus.wb_csr_wdata = 32'h222; #1;
        checks++; if (bus.wb_ovf !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", bus.wb_ovf); end
        @(negedge clk); bus.wb_csr_wen = 1'b0; #1;
        checks++; if (bus.wb_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", bus.wb_ovf); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if ({bus.busy, bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b0, 1'b1, 12'h305, 32'h111}) begin failures++; $display("FAIL ovf_first_kept got=%h exp=%h", {bus.busy, bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b0, 1'b1, 12'h305, 32'h111}); end
        @(negedge clk); #1;
        checks++; if ({bus.csr_wen, bus.wb_ovf} !== 2'b01) begin failures++; $display("FAIL ovf_second_dropped got=%b exp=01", {bus.csr_wen, bus.wb_ovf}); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle_inputs();
        bus.mtvec_in = 32'h400; bus.trap_cause = 32'd3; bus.trap_pc = 32'h80; bus.trap_tval = 32'h77;
        bus.trap_req = 1'b1;
        @(negedge clk); bus.trap_req = 1'b0;
        @(negedge clk); #1;
        checks++; if ({bus.csr_wen, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h342, 32'd3}) begin failures++; $display("FAIL rmid_pre got=%h exp=%h", {bus.csr_wen, bus.csr_waddr, bus.csr_wdata}, {1'b1, 12'h342, 32'd3}); end
        rst = 1'b1; #1;
        checks++; if ({bus.busy, bus.csr_wen, bus.redirect_valid, bus.trap_ack, bus.wb_ovf} !== 5'b0) begin failures++; $display("FAIL rmid_outputs got=%b exp=00000", {bus.busy, bus.csr_wen, bus.redirect_valid, bus.trap_ack, bus.wb_ovf}); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            checks++; if ({bus.busy, bus.csr_wen, bus.redirect_valid} !== 3'b000) begin failures++; $display("FAIL rmid_after_%0d got=%b exp=000", i, {bus.busy, bus.csr_wen, bus.redirect_valid}); end
        end
    endtask

    initial begin
        test_reset();
        test_sync_trap();
        test_vectored();
        test_mret();
        test_priority();
        test_wb_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csr_trap_ctrl.md
CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high, ports named clk and rst.
REQ-002 SHALL have parameter VEC_EN, default 1, meaning vectored mtvec mode is honoured (0 = always direct).
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 wb_csr_wen / wb_csr_waddr / wb_csr_wdata  in  1/12/32  CSR write from WB stage.
REQ-006 trap_req / trap_cause / trap_pc / trap_tval  in  1/32/32/32  trap request, held until trap_ack.
REQ-007 mret_req  in  1  mret request, held until mret_ack.
REQ-008 mstatus_in / mtvec_in / mepc_in  in  32 each  current csr_file contents.
REQ-009 csr_wen / csr_waddr / csr_wdata  out  1/12/32  arbitrated write port to csr_file.
REQ-010 trap_ack / mret_ack  out  1 each  one-cycle acceptance pulses.
REQ-011 busy  out  1  high while state != IDLE; pipeline stalls on it.
REQ-012 redirect_valid / redirect_pc  out  1/32  one-cycle fetch redirect.
REQ-013 wb_ovf  out  1  sticky: a WB write was lost.

Function
REQ-014 SHALL use the CSR addresses 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x343 mtval.
REQ-015 SHALL implement FSM states IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, M_STAT, REDIR.
REQ-016 In IDLE, trap_req SHALL win over mret_req in the same cycle; the loser stays unacknowledged.
REQ-017 On trap acceptance in IDLE at cycle T, SHALL pulse trap_ack at T and latch cause/pc/tval/mtvec_in.
REQ-018 Writes SHALL follow acceptance at T:
- T+1: mepc = {trap_pc[31:2],2'b00}
- T+2: mcause
- T+3: mtval
- T+4: mstatus
- T+5: REDIR
REQ-019 T_STAT SHALL write mstatus_in sampled that cycle with MPIE=MIE(bit3), MIE=0, MPP[12:11]=2'b11; other bits unchanged.
REQ-020 Trap redirect_pc SHALL be {mtvec[31:2],2'b00} + 4*cause[30:0] when VEC_EN and mtvec[1:0]==01 and cause[31]==1; otherwise {mtvec[31:2],2'b00}; arithmetic mod 2^32.
REQ-021 On mret acceptance at T, SHALL pulse mret_ack at T, write mstatus at T+1 (MIE=MPIE, MPIE=1, MPP=11), and REDIR at T+2 with redirect_pc={mepc_in[31:2],2'b00} sampled at T+1.
REQ-022 REDIR SHALL assert redirect_valid for exactly one cycle, then return to IDLE; requests present in REDIR SHALL be ignored.
REQ-023 While busy, requests SHALL not be acknowledged and csr_wen SHALL carry only sequencer writes.
REQ-024 SHALL have a one-entry pending buffer for WB writes; a WB write arriving while busy SHALL be captured into it.
REQ-025 A WB write arriving while busy with pending already valid SHALL be dropped and set wb_ovf; the existing pending entry is kept.
REQ-026 In IDLE, pending (if valid) SHALL drive the write port; a simultaneous live WB write SHALL replace the pending entry (no overflow).
REQ-027 In IDLE with no pending entry, a live WB write SHALL pass combinationally to csr_wen/addr/data, including in the cycle a trap or mret is accepted.
REQ-028 csr_wen SHALL be 0 in IDLE when there is no pending entry and no WB write, and 0 in REDIR.

Reset
REQ-029 rst SHALL force: state IDLE, pending cleared, wb_ovf=0, latched fields 0, and all outputs 0 (busy, acks, redirect, csr_wen).
REQ-030 rst mid-sequence SHALL abort it; no further sequencer writes or redirect occur after release.

Verification
REQ-031 Sync trap: mtvec_in=0x80000100, cause=2, pc=0x1004, tval=0xDEAD -> writes 0x341=0x1004, 0x342=2, 0x343=0xDEAD on T+1..T+3; redirect 0x80000100 at T+5.
REQ-032 Vectored interrupt: mtvec_in=0x80000101, cause=0x80000007 -> redirect_pc=0x8000011C.
REQ-033 mret: mstatus_in=0x00000080, mepc_in=0x2002 -> mstatus write 0x00001888 at T+1, redirect 0x2000 at T+2.
REQ-034 trap_req with mret_req and WB write (0x305, 0x40) in one IDLE cycle -> WB write on port at T, trap_ack=1, mret_ack=0.
REQ-035 Two WB writes while busy -> first issued in the first IDLE cycle, second dropped, wb_ovf=1.
REQ-036 rst asserted at T+2 of a trap -> all outputs 0; after release no mtval/mstatus writes and no redirect.
